// File: rtl/trap_sequencer_pkg.sv
// Shared definitions for the machine-mode trap sequencer: FSM states,
// cause codes, mtvec mode values and the trap target computation.
package trap_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRAP  = 2'd1,
        ST_REDIR = 2'd2,
        ST_DRAIN = 2'd3
    } trap_state_e;

    localparam logic [4:0] CAUSE_ILLEGAL = 5'd2;
    localparam logic [4:0] CAUSE_MSI     = 5'd3;
    localparam logic [4:0] CAUSE_MTI     = 5'd7;
    localparam logic [4:0] CAUSE_ECALL   = 5'd11;
    localparam logic [4:0] CAUSE_MEI     = 5'd11;

    localparam logic [1:0] MTVEC_VECTORED = 2'b01;

    // Vectored mode offsets the base by the cause for interrupts only;
    // exceptions and the reserved modes always land on the base.
    function automatic logic [29:0] trap_target(input logic [31:0] mtvec,
                                                input logic        is_irq,
                                                input logic [4:0]  cause);
        if (is_irq && (mtvec[1:0] == MTVEC_VECTORED))
            return mtvec[31:2] + {25'b0, cause};
        return mtvec[31:2];
    endfunction

endpackage

// File: rtl/trap_sequencer_irq_sync.sv
// Multi-stage synchronizer for an asynchronous level input.
module irq_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic sync_out
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // Shift the raw input into the chain one stage per cycle.
    always_comb begin
        sync_d    = sync_q << 1;
        sync_d[0] = async_in;
    end

    // Synchronizer flops, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= sync_d;
    end

    assign sync_out = sync_q[STAGES-1];

endmodule

// File: rtl/trap_sequencer.sv
// Machine-mode trap controller: arbitrates exceptions and interrupts,
// pulses the CSR file, redirects fetch and flushes the pipeline.
module trap_sequencer
    import trap_sequencer_pkg::*;
#(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ext_irq,
    input  logic        soft_irq,
    input  logic        timer_irq,
    input  logic        csr_rmie,
    input  logic        csr_meie,
    input  logic        csr_msie,
    input  logic        csr_mtie,
    input  logic        illegal_ops_ex,
    input  logic        cmd_ecall_ex,
    input  logic        cmd_mret_ex,
    input  logic        stall,
    input  logic [31:0] csr_mtvec,
    input  logic [29:0] csr_mepc_ex,
    output logic        g_interrupt,
    output logic        g_exception,
    output logic [4:0]  trap_cause,
    output logic        pc_redirect,
    output logic [29:0] redirect_pc,
    output logic        flush_pipe,
    output logic        trap_busy
);

    localparam int unsigned CW = $clog2(DRAIN_CYCLES + 1);

    trap_state_e state_q, state_d;
    logic [4:0]    cause_q, cause_d;
    logic          is_irq_q, is_irq_d;
    logic [29:0]   target_q, target_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic       ext_s;
    logic [2:0] irq_pend;
    logic       take_trap;
    logic       take_irq;
    logic [4:0] new_cause;

    irq_sync #(.STAGES(SYNC_STAGES)) u_ext_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (ext_irq),
        .sync_out (ext_s)
    );

    // Prioritise events in IDLE, advance the fixed-length sequence, drive outputs.
    always_comb begin
        state_d     = state_q;
        cause_d     = cause_q;
        is_irq_d    = is_irq_q;
        target_d    = target_q;
        cnt_d       = cnt_q;
        take_trap   = 1'b0;
        take_irq    = 1'b0;
        new_cause   = cause_q;
        irq_pend    = {ext_s & csr_meie, soft_irq & csr_msie, timer_irq & csr_mtie};

        g_interrupt = 1'b0;
        g_exception = 1'b0;
        pc_redirect = 1'b0;
        redirect_pc = '0;
        flush_pipe  = 1'b0;
        trap_busy   = (state_q != ST_IDLE);

        unique case (state_q)
            ST_IDLE: begin
                if (!stall) begin
                    if (illegal_ops_ex) begin
                        take_trap = 1'b1;
                        new_cause = CAUSE_ILLEGAL;
                    end else if (cmd_ecall_ex) begin
                        take_trap = 1'b1;
                        new_cause = CAUSE_ECALL;
                    end else if (cmd_mret_ex) begin
                        state_d  = ST_REDIR;
                        target_d = csr_mepc_ex;
                    end else if (csr_rmie && (irq_pend != 3'b000)) begin
                        take_trap = 1'b1;
                        take_irq  = 1'b1;
                        if (irq_pend[2])      new_cause = CAUSE_MEI;
                        else if (irq_pend[1]) new_cause = CAUSE_MSI;
                        else                  new_cause = CAUSE_MTI;
                    end
                end
                if (take_trap) begin
                    state_d  = ST_TRAP;
                    cause_d  = new_cause;
                    is_irq_d = take_irq;
                    target_d = trap_target(csr_mtvec, take_irq, new_cause);
                end
            end
            ST_TRAP: begin
                g_interrupt = is_irq_q;
                g_exception = !is_irq_q;
                state_d     = ST_REDIR;
            end
            ST_REDIR: begin
                pc_redirect = 1'b1;
                redirect_pc = target_q;
                flush_pipe  = 1'b1;
                cnt_d       = CW'(DRAIN_CYCLES - 1);
                state_d     = ST_DRAIN;
            end
            ST_DRAIN: begin
                flush_pipe = 1'b1;
                if (cnt_q == '0) state_d = ST_IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, latched cause and redirect target.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cause_q  <= '0;
            is_irq_q <= 1'b0;
            target_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            cause_q  <= cause_d;
            is_irq_q <= is_irq_d;
            target_q <= target_d;
            cnt_q    <= cnt_d;
        end
    end

    assign trap_cause = cause_q;

endmodule
